// File: rtl/serdes_pkg.sv
// Constants and state encoding shared by the SERDES link endpoints.
// The OSERDES test top uses TRAINING_WORD_DEF to emit the training pattern.
package serdes_pkg;

    localparam int              DDR_W             = 8;
    localparam logic [DDR_W-1:0] TRAINING_WORD_DEF = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_e;

endpackage

// File: rtl/iserdes_word_aligner.sv
// Receive word aligner: issues ISERDESE2 BITSLIP pulses until the training
// word is seen MATCH_COUNT times in a row, then forwards parallel words.
module iserdes_word_aligner
    import serdes_pkg::*;
#(
    parameter logic [DDR_W-1:0] TRAINING_WORD = TRAINING_WORD_DEF,
    parameter int               SETTLE_CYCLES = 3,
    parameter int               MATCH_COUNT   = 16,
    parameter int               MAX_SLIPS     = 8,
    localparam int              SLIP_W        = $clog2(MAX_SLIPS + 1),
    localparam int              SET_W         = $clog2(SETTLE_CYCLES + 1),
    localparam int              MATCH_W       = $clog2(MATCH_COUNT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              realign,
    input  logic [DDR_W-1:0]  din,
    output logic              bitslip,
    output logic              aligned,
    output logic              fail,
    output logic [DDR_W-1:0]  dout,
    output logic              dout_valid,
    output logic [SLIP_W-1:0] slip_count
);

    state_e             state_q, state_d;
    logic [SET_W-1:0]   settle_q, settle_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [SLIP_W-1:0]  slip_q, slip_d;
    logic               bitslip_q, bitslip_d;
    logic               aligned_q, aligned_d;
    logic               fail_q, fail_d;
    logic               dv_q, dv_d;
    logic [DDR_W-1:0]   dout_q, dout_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            match_q   <= '0;
            slip_q    <= '0;
            bitslip_q <= 1'b0;
            aligned_q <= 1'b0;
            fail_q    <= 1'b0;
            dv_q      <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            match_q   <= match_d;
            slip_q    <= slip_d;
            bitslip_q <= bitslip_d;
            aligned_q <= aligned_d;
            fail_q    <= fail_d;
            dv_q      <= dv_d;
            dout_q    <= dout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        match_d   = match_q;
        slip_d    = slip_q;
        bitslip_d = 1'b0;
        aligned_d = 1'b0;
        fail_d    = 1'b0;
        dv_d      = 1'b0;
        dout_d    = dout_q;

        if (!enable) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            match_d  = '0;
            slip_d   = '0;
        end else if (realign) begin
            state_d  = ST_SETTLE;
            settle_d = '0;
            match_d  = '0;
            slip_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
                ST_SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_CHECK;
                        match_d = '0;
                    end else begin
                        settle_d = settle_q + SET_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (din == TRAINING_WORD) begin
                        if (match_q == MATCH_W'(MATCH_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            match_d = MATCH_W'(MATCH_COUNT);
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else if (slip_q < SLIP_W'(MAX_SLIPS)) begin
                        // Pulse is registered so it is high for exactly the SLIP cycle.
                        state_d   = ST_SLIP;
                        slip_d    = slip_q + SLIP_W'(1);
                        bitslip_d = 1'b1;
                        match_d   = '0;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
                ST_LOCKED: ;
                ST_FAIL:   ;
                default:   state_d = ST_IDLE;
            endcase
        end

        aligned_d = (state_d == ST_LOCKED);
        fail_d    = (state_d == ST_FAIL);
        // Only words sampled while already locked are payload; the locking word is not.
        if (state_q == ST_LOCKED && state_d == ST_LOCKED) begin
            dv_d   = 1'b1;
            dout_d = din;
        end
    end

    assign bitslip    = bitslip_q;
    assign aligned    = aligned_q;
    assign fail       = fail_q;
    assign dout       = dout_q;
    assign dout_valid = dv_q;
    assign slip_count = slip_q;

endmodule
